// File: rtl/pe_cfg_rx.sv
// Port-E configuration link receiver: synchronises the host pins, deserialises a
// LSB-first frame, and commits it on the load strobe after a bit-count check.
module pe_cfg_rx #(
   parameter int unsigned WIDTH       = 56,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pe_clk,
   input  logic             pe_data,
   input  logic             pe_load,
   output logic [WIDTH-1:0] cfg_word,
   output logic [1:0]       cfg_mode,
   output logic [15:0]      cfg_div,
   output logic [31:0]      cfg_val,
   output logic             cfg_valid,
   output logic             cfg_err,
   output logic [5:0]       bit_cnt
);

   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_SHIFT = 1'b0, S_LOADED = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync, data_sync, load_sync;
   logic                 clk_s, data_s, load_s;
   logic                 clk_d, load_d;
   logic                 clk_rise_q, load_rise_q, data_q;
   logic [WIDTH-1:0]     sreg, sreg_nxt, word_nxt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 valid_nxt, err_nxt;

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign load_s = load_sync[SYNC_STAGES-1];

   // Synchronisers plus registered edge detect; data is delayed to stay aligned with the clock event
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync    <= '0;
         data_sync   <= '0;
         load_sync   <= '0;
         clk_d       <= 1'b0;
         load_d      <= 1'b0;
         clk_rise_q  <= 1'b0;
         load_rise_q <= 1'b0;
         data_q      <= 1'b0;
      end else begin
         clk_sync    <= {clk_sync[SYNC_STAGES-2:0], pe_clk};
         data_sync   <= {data_sync[SYNC_STAGES-2:0], pe_data};
         load_sync   <= {load_sync[SYNC_STAGES-2:0], pe_load};
         clk_d       <= clk_s;
         load_d      <= load_s;
         clk_rise_q  <= clk_s & ~clk_d;
         load_rise_q <= load_s & ~load_d;
         data_q      <= data_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_SHIFT;
         sreg      <= '0;
         bit_cnt   <= '0;
         cfg_word  <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bit_cnt   <= cnt_nxt;
         cfg_word  <= word_nxt;
         cfg_valid <= valid_nxt;
         cfg_err   <= err_nxt;
      end
   end

   // Load wins over a coincident shift clock; the clock edge is simply dropped
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      cnt_nxt   = bit_cnt;
      word_nxt  = cfg_word;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         S_SHIFT: begin
            if (load_rise_q) begin
               if (bit_cnt == CNT_W'(WIDTH)) begin
                  word_nxt  = sreg;
                  valid_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
               cnt_nxt   = '0;
               sreg_nxt  = '0;
               state_nxt = S_LOADED;
            end else if (clk_rise_q) begin
               sreg_nxt = {data_q, sreg[WIDTH-1:1]};
               if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
            end
         end
         S_LOADED: begin
            if (!load_s) state_nxt = S_SHIFT;
         end
         default: state_nxt = S_SHIFT;
      endcase
   end

   assign cfg_mode = cfg_word[55:54];
   assign cfg_div  = cfg_word[47:32];
   assign cfg_val  = cfg_word[31:0];

endmodule

// File: tb/tb_pe_cfg_rx.sv
// Directed bench for pe_cfg_rx: drives host-side frames and checks commit, errors and decode.
module tb_pe_cfg_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pe_clk = 1'b0;
   logic        pe_data = 1'b0;
   logic        pe_load = 1'b0;
   logic [55:0] cfg_word;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_div;
   logic [31:0] cfg_val;
   logic        cfg_valid;
   logic        cfg_err;
   logic [5:0]  bit_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   pe_cfg_rx #(.WIDTH(56), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .pe_clk(pe_clk), .pe_data(pe_data), .pe_load(pe_load),
      .cfg_word(cfg_word), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_val(cfg_val),
      .cfg_valid(cfg_valid), .cfg_err(cfg_err), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (cfg_valid) valid_cnt++;
      if (cfg_err) err_cnt++;
      if (cfg_valid && cfg_err) both_cnt++;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      pe_data = b;
      wait_clks(4);
      pe_clk = 1'b1;
      wait_clks(4);
      pe_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [55:0] md, input int n);
      for (int i = 0; i < n; i++) send_bit(md[i % 56]);
      wait_clks(4);
   endtask

   task automatic load_pulse();
      pe_load = 1'b1;
      wait_clks(8);
      pe_load = 1'b0;
      wait_clks(8);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_clks(3);
      n_cmp++; if (cfg_word !== 56'h0) begin n_bad++; $display("FAIL reset_word got=%h exp=0", cfg_word); end
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_bitcnt got=%0d exp=0", bit_cnt); end
      n_cmp++; if ({cfg_valid, cfg_err} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got=%b exp=00", {cfg_valid, cfg_err}); end
      reset = 1'b0;
      wait_clks(2);
   endtask

   task automatic test_nominal();
      logic [55:0] md;
      int v0, e0, lat;
      md = {2'b01, 6'b0, 16'd3, 32'd0};
      v0 = valid_cnt; e0 = err_cnt; lat = 0;
      send_bits(md, 56);
      n_cmp++; if (bit_cnt !== 6'd56) begin n_bad++; $display("FAIL nom_bitcnt got=%0d exp=56", bit_cnt); end
      pe_load = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (cfg_valid && lat == 0) lat = k;
      end
      wait_clks(1);
      pe_load = 1'b0;
      wait_clks(8);
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL nom_latency got=%0d exp=4", lat); end
      n_cmp++; if (cfg_word !== 56'h40000300000000) begin n_bad++; $display("FAIL nom_word got=%h exp=40000300000000", cfg_word); end
      n_cmp++; if (cfg_mode !== 2'd1) begin n_bad++; $display("FAIL nom_mode got=%0d exp=1", cfg_mode); end
      n_cmp++; if (cfg_div !== 16'd3) begin n_bad++; $display("FAIL nom_div got=%0d exp=3", cfg_div); end
      n_cmp++; if (cfg_val !== 32'd0) begin n_bad++; $display("FAIL nom_val got=%h exp=0", cfg_val); end
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL nom_valid_pulses got=%0d exp=1", valid_cnt - v0); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL nom_err_pulses got=%0d exp=0", err_cnt - e0); end
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL nom_bitcnt_after got=%0d exp=0", bit_cnt); end
   endtask

   task automatic test_short();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(56'hFF_FFFF_FFFF_FFFF, 55);
      n_cmp++; if (bit_cnt !== 6'd55) begin n_bad++; $display("FAIL short_bitcnt got=%0d exp=55", bit_cnt); end
      load_pulse();
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL short_err got=%0d exp=1", err_cnt - e0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL short_valid got=%0d exp=0", valid_cnt - v0); end
      n_cmp++; if (cfg_word !== 56'h40000300000000) begin n_bad++; $display("FAIL short_word got=%h exp=40000300000000", cfg_word); end
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL short_bitcnt_after got=%0d exp=0", bit_cnt); end
   endtask

   task automatic test_overrun();
      int e0, v0;
      e0 = err_cnt; v0 = valid_cnt;
      send_bits(56'h12_3456_789A_BCDE, 57);
      load_pulse();
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL over57_err got=%0d exp=1", err_cnt - e0); end
      e0 = err_cnt;
      send_bits(56'h12_3456_789A_BCDE, 70);
      n_cmp++; if (bit_cnt !== 6'd63) begin n_bad++; $display("FAIL over70_sat got=%0d exp=63", bit_cnt); end
      load_pulse();
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL over70_err got=%0d exp=1", err_cnt - e0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL over_valid got=%0d exp=0", valid_cnt - v0); end
      n_cmp++; if (cfg_word !== 56'h40000300000000) begin n_bad++; $display("FAIL over_word got=%h exp=40000300000000", cfg_word); end
   endtask

   task automatic test_coincident();
      logic [55:0] md;
      int v0, e0;
      md = 56'h80_1234_DEAD_BEEF;
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(md, 56);
      pe_data = 1'b1;
      pe_clk  = 1'b1;
      pe_load = 1'b1;
      wait_clks(8);
      pe_clk = 1'b0;
      pe_load = 1'b0;
      wait_clks(8);
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL coin_valid got=%0d exp=1", valid_cnt - v0); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL coin_err got=%0d exp=0", err_cnt - e0); end
      n_cmp++; if (cfg_word !== md) begin n_bad++; $display("FAIL coin_word got=%h exp=%h", cfg_word, md); end
      n_cmp++; if (cfg_mode !== 2'd2) begin n_bad++; $display("FAIL coin_mode got=%0d exp=2", cfg_mode); end
      n_cmp++; if (cfg_div !== 16'h1234) begin n_bad++; $display("FAIL coin_div got=%h exp=1234", cfg_div); end
      n_cmp++; if (cfg_val !== 32'hDEADBEEF) begin n_bad++; $display("FAIL coin_val got=%h exp=deadbeef", cfg_val); end
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL coin_bitcnt got=%0d exp=0", bit_cnt); end
   endtask

   task automatic test_clk_during_load();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      pe_load = 1'b1;
      wait_clks(8);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      wait_clks(4);
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL hold_bitcnt got=%0d exp=0", bit_cnt); end
      pe_load = 1'b0;
      wait_clks(8);
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL hold_bitcnt_after got=%0d exp=0", bit_cnt); end
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL hold_err got=%0d exp=1", err_cnt - e0); end
      n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL hold_valid got=%0d exp=0", valid_cnt - v0); end
      n_cmp++; if (cfg_word !== 56'h80_1234_DEAD_BEEF) begin n_bad++; $display("FAIL hold_word got=%h exp=801234deadbeef", cfg_word); end
   endtask

   task automatic test_reset_mid();
      logic [55:0] md;
      int v0, e0;
      send_bits(56'hAA_AAAA_AAAA_AAAA, 20);
      reset = 1'b1;
      wait_clks(1);
      reset = 1'b0;
      wait_clks(2);
      n_cmp++; if (cfg_word !== 56'h0) begin n_bad++; $display("FAIL rmid_word got=%h exp=0", cfg_word); end
      n_cmp++; if (bit_cnt !== 6'd0) begin n_bad++; $display("FAIL rmid_bitcnt got=%0d exp=0", bit_cnt); end
      md = {2'b00, 6'b0, 16'h0, 32'h3f800000};
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(md, 56);
      load_pulse();
      n_cmp++; if (cfg_val !== 32'h3f800000) begin n_bad++; $display("FAIL rmid_val got=%h exp=3f800000", cfg_val); end
      n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL rmid_valid got=%0d exp=1", valid_cnt - v0); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL rmid_err got=%0d exp=0", err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      logic [55:0] md1, md2;
      int v0, e0;
      md1 = {2'b01, 6'b0, 16'd3, 32'h0000_0001};
      md2 = {2'b11, 6'b0, 16'hABCD, 32'h5555_AAAA};
      v0 = valid_cnt; e0 = err_cnt;
      send_bits(md1, 56);
      pe_load = 1'b1;
      wait_clks(6);
      pe_load = 1'b0;
      wait_clks(4);
      send_bits(md2, 56);
      load_pulse();
      n_cmp++; if (valid_cnt - v0 !== 2) begin n_bad++; $display("FAIL b2b_valid got=%0d exp=2", valid_cnt - v0); end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - e0); end
      n_cmp++; if (cfg_div !== 16'hABCD) begin n_bad++; $display("FAIL b2b_div got=%h exp=abcd", cfg_div); end
      n_cmp++; if (cfg_mode !== 2'd3) begin n_bad++; $display("FAIL b2b_mode got=%0d exp=3", cfg_mode); end
      n_cmp++; if (cfg_val !== 32'h5555AAAA) begin n_bad++; $display("FAIL b2b_val got=%h exp=5555aaaa", cfg_val); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short();
      test_overrun();
      test_coincident();
      test_clk_during_load();
      test_reset_mid();
      test_back_to_back();
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL valid_err_overlap got=%0d exp=0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
